// File: rtl/flit_inject_eject_if.sv
// PE-side handshake bundle for the BLESS local injection/ejection stage:
// injection offer (valid/ready) and ejected-flit delivery.
interface flit_inject_eject_if #(
    parameter int DATA_W = 32,
    parameter int DST_W  = 4,
    parameter int TIME_W = 8
);
    localparam int W = 1 + TIME_W + DST_W + DATA_W;

    logic              inj_valid;
    logic              inj_ready;
    logic [DST_W-1:0]  inj_dst;
    logic [DATA_W-1:0] inj_data;
    logic              eject_ready;
    logic              eject_valid;
    logic [W-1:0]      eject_flit;

    // Processing element side.
    modport master (
        output inj_valid, inj_dst, inj_data, eject_ready,
        input  inj_ready, eject_valid, eject_flit
    );

    // Router side.
    modport slave (
        input  inj_valid, inj_dst, inj_data, eject_ready,
        output inj_ready, eject_valid, eject_flit
    );
endinterface

// File: rtl/flit_inject_eject.sv
// BLESS local-node stage: ejects the oldest flit destined here and injects
// buffered PE traffic into a free channel slot, at most one of each per cycle.
module flit_inject_eject #(
    parameter int DATA_W    = 32,
    parameter int DST_W     = 4,
    parameter int TIME_W    = 8,
    parameter int NODE_ID   = 0,
    parameter int INJ_DEPTH = 4,
    localparam int W        = 1 + TIME_W + DST_W + DATA_W,
    localparam int CNT_W    = $clog2(INJ_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W-1:0]       din0,
    input  logic [W-1:0]       din1,
    input  logic [W-1:0]       din2,
    input  logic [W-1:0]       din3,
    output logic [W-1:0]       dout0,
    output logic [W-1:0]       dout1,
    output logic [W-1:0]       dout2,
    output logic [W-1:0]       dout3,
    flit_inject_eject_if.slave pe,
    output logic [CNT_W-1:0]   fifo_count,
    output logic [TIME_W-1:0]  time_now
);
    localparam int NPORT = 4;
    localparam int PTR_W = $clog2(INJ_DEPTH);
    localparam logic [DST_W-1:0] LOCAL_ID = DST_W'(NODE_ID);

    typedef struct packed {
        logic              valid;
        logic [TIME_W-1:0] stamp;
        logic [DST_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } flit_t;

    typedef logic [1:0] slot_t;

    flit_t             din_f   [NPORT];
    flit_t             dout_d  [NPORT];
    flit_t             dout_q  [NPORT];
    flit_t             eject_q;
    logic              eject_valid_q;

    flit_t             fifo_mem [INJ_DEPTH];
    flit_t             fifo_head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              enq;
    logic              deq;

    logic              eject_hit;
    slot_t             eject_idx;
    logic [TIME_W-1:0] eject_stamp;
    logic [NPORT-1:0]  slot_free;
    logic              inj_hit;
    slot_t             inj_idx;

    assign din_f[0] = din0;
    assign din_f[1] = din1;
    assign din_f[2] = din2;
    assign din_f[3] = din3;

    assign dout0 = dout_q[0];
    assign dout1 = dout_q[1];
    assign dout2 = dout_q[2];
    assign dout3 = dout_q[3];

    assign pe.eject_valid = eject_valid_q;
    assign pe.eject_flit  = eject_q;

    assign fifo_empty   = (fifo_count == '0);
    assign fifo_full    = (fifo_count == CNT_W'(INJ_DEPTH));
    assign pe.inj_ready = !fifo_full;
    assign enq          = pe.inj_valid && !fifo_full;
    assign deq          = inj_hit;
    assign fifo_head    = fifo_mem[rd_ptr];

    // Oldest local flit wins; the strict compare keeps the lowest index on ties.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        eject_hit   = 1'b0;
        eject_idx   = '0;
        eject_stamp = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (pe.eject_ready && din_f[i].valid && din_f[i].dst == LOCAL_ID &&
                (!eject_hit || din_f[i].stamp < eject_stamp)) begin
                eject_hit   = 1'b1;
                eject_idx   = slot_t'(i);
                eject_stamp = din_f[i].stamp;
            end
        end
    end

    // Ejection resolves first, so the FIFO head may reuse the slot just emptied.
    always_comb begin
        slot_free = '0;
        inj_hit   = 1'b0;
        inj_idx   = '0;
        for (int i = 0; i < NPORT; i++) begin
            slot_free[i] = !din_f[i].valid || (eject_hit && eject_idx == slot_t'(i));
            if (slot_free[i] && !fifo_empty && !inj_hit) begin
                inj_hit = 1'b1;
                inj_idx = slot_t'(i);
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            dout_d[i] = slot_free[i] ? flit_t'('0) : din_f[i];
            if (inj_hit && inj_idx == slot_t'(i)) begin
                dout_d[i] = fifo_head;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_now      <= '0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            eject_valid_q <= 1'b0;
            eject_q       <= '0;
            for (int i = 0; i < NPORT; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            time_now <= time_now + TIME_W'(1);

            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase

            eject_valid_q <= eject_hit;
            if (eject_hit) begin
                eject_q <= din_f[eject_idx];
            end

            for (int i = 0; i < NPORT; i++) begin
                dout_q[i] <= dout_d[i];
            end
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers alone decide
    // which entries are live, so clearing them discards the contents.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= '{valid: 1'b1, stamp: time_now,
                                  dst: pe.inj_dst, data: pe.inj_data};
        end
    end
endmodule

// File: tb/tb_flit_inject_eject.sv
// Self-checking bench for flit_inject_eject: directed vectors, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_flit_inject_eject;
    localparam int DATA_W = 32;
    localparam int DST_W  = 4;
    localparam int TIME_W = 8;
    localparam int NODE   = 5;
    localparam int DEPTH  = 4;
    localparam int W      = 1 + TIME_W + DST_W + DATA_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct {
        logic [3:0][W-1:0] din;
        logic              er;
        logic [3:0][W-1:0] dout;
        logic              ev;
        logic [W-1:0]      ef;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [W-1:0]      din [4];
    logic [W-1:0]      dout0, dout1, dout2, dout3;
    logic [CNT_W-1:0]  fifo_count;
    logic [TIME_W-1:0] time_now;

    flit_inject_eject_if #(.DATA_W(DATA_W), .DST_W(DST_W), .TIME_W(TIME_W)) pe ();

    flit_inject_eject #(
        .DATA_W(DATA_W), .DST_W(DST_W), .TIME_W(TIME_W),
        .NODE_ID(NODE), .INJ_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .pe(pe), .fifo_count(fifo_count), .time_now(time_now)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: FIFO as a queue, time as an integer.
    logic [W-1:0] mq [$];
    int           tnow;
    logic [W-1:0] e_dout [4];
    logic         e_ev;
    logic [W-1:0] e_ef;

    vec_t vecs [6];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(bit v, int t, int d, logic [DATA_W-1:0] data);
        return {v, TIME_W'(t), DST_W'(d), data};
    endfunction

    function automatic int tfield(logic [W-1:0] f);
        return int'(f[W-2 -: TIME_W]);
    endfunction

    function automatic int dfield(logic [W-1:0] f);
        return int'(f[DATA_W +: DST_W]);
    endfunction

    function automatic vec_t mkvec(logic [W-1:0] d0, d1, d2, d3, logic er,
                                   logic [W-1:0] o0, o1, o2, o3, logic ev, logic [W-1:0] ef);
        vec_t v;
        v.din  = {d3, d2, d1, d0};
        v.er   = er;
        v.dout = {o3, o2, o1, o0};
        v.ev   = ev;
        v.ef   = ef;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        tnow = 0;
        e_ev = 1'b0;
        e_ef = '0;
        for (int i = 0; i < 4; i++) e_dout[i] = '0;
    endtask

    // One cycle of the specified behaviour, from the inputs currently driven.
    task automatic model_step();
        bit           ready;
        bit           done;
        int           best;
        int           bestkey;
        int           key;
        logic [W-1:0] out [4];
        ready   = (mq.size() < DEPTH);
        best    = -1;
        bestkey = 0;
        done    = 0;
        if (pe.eject_ready) begin
            for (int i = 0; i < 4; i++) begin
                if (din[i][W-1] && dfield(din[i]) == NODE) begin
                    key = tfield(din[i]) * 4 + i;
                    if (best < 0 || key < bestkey) begin
                        best    = i;
                        bestkey = key;
                    end
                end
            end
        end
        e_ev = (best >= 0);
        if (best >= 0) e_ef = din[best];
        for (int i = 0; i < 4; i++) begin
            out[i] = (!din[i][W-1] || i == best) ? '0 : din[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (!done && (!din[i][W-1] || i == best) && mq.size() > 0) begin
                out[i] = mq.pop_front();
                done   = 1;
            end
        end
        if (pe.inj_valid && ready) mq.push_back(mk(1, tnow, int'(pe.inj_dst), pe.inj_data));
        tnow = (tnow + 1) % (1 << TIME_W);
        for (int i = 0; i < 4; i++) e_dout[i] = out[i];
    endtask

    task automatic check_all();
        check("dout0", dout0, e_dout[0]);
        check("dout1", dout1, e_dout[1]);
        check("dout2", dout2, e_dout[2]);
        check("dout3", dout3, e_dout[3]);
        check("eject_valid", pe.eject_valid, e_ev);
        check("eject_flit", pe.eject_flit, e_ef);
        check("fifo_count", fifo_count, mq.size());
        check("inj_ready", pe.inj_ready, mq.size() < DEPTH);
        check("time_now", time_now, tnow);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) din[i] = '0;
        pe.inj_valid   = 1'b0;
        pe.inj_dst     = '0;
        pe.inj_data    = '0;
        pe.eject_ready = 1'b0;
    endtask

    // Reset takes effect at once, mid-cycle, then is held across one edge.
    task automatic apply_reset();
        reset = 1'b1;
        #2;
        check("rst dout0", dout0, 0);
        check("rst dout1", dout1, 0);
        check("rst dout2", dout2, 0);
        check("rst dout3", dout3, 0);
        check("rst fifo_count", fifo_count, 0);
        check("rst eject_valid", pe.eject_valid, 0);
        check("rst eject_flit", pe.eject_flit, 0);
        check("rst time_now", time_now, 0);
        check("rst inj_ready", pe.inj_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic all_nonlocal();
        for (int i = 0; i < 4; i++) din[i] = mk(1, 10 + i, 1, 32'hC0 + i);
    endtask

    initial begin
        logic [W-1:0] a, b, d, p, q, x, y, f0, f1, f2, f3, g0, g1, loc;
        int  stamp;
        int  n_enq;
        bit  rdy [6];

        a  = mk(1, 2, 3, 32'hA0);  b  = mk(1, 9, 5, 32'h11);  d  = mk(1, 4, 5, 32'h33);
        p  = mk(1, 7, 5, 32'h1);   q  = mk(1, 7, 5, 32'h2);
        x  = mk(0, 1, 5, 32'h77);  y  = mk(1, 0, 6, 32'h5);
        f0 = mk(1, 3, 5, 32'h1);   f1 = mk(1, 3, 5, 32'h2);
        f2 = mk(1, 1, 5, 32'h3);   f3 = mk(1, 200, 5, 32'h4);
        g0 = mk(1, 255, 5, 32'h9); g1 = mk(1, 0, 5, 32'hA);
        vecs[0] = mkvec(a, b, '0, d, 1,  a, b, '0, '0, 1, d);    // oldest local ejected
        vecs[1] = mkvec(a, b, '0, d, 0,  a, b, '0, d, 0, '0);    // blocked: deflected
        vecs[2] = mkvec(p, '0, q, '0, 1, '0, '0, q, '0, 1, p);   // tie: lowest index
        vecs[3] = mkvec(x, y, '0, '0, 1, '0, y, '0, '0, 0, '0);  // invalid local ignored
        vecs[4] = mkvec(f0, f1, f2, f3, 1, f0, f1, '0, f3, 1, f2);
        vecs[5] = mkvec(g0, g1, '0, '0, 1, g0, '0, '0, '0, 1, g1); // unsigned, no wrap fix

        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        apply_reset();

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) din[i] = vecs[k].din[i];
            pe.eject_ready = vecs[k].er;
            cycle();
            check("vec dout0", dout0, vecs[k].dout[0]);
            check("vec dout1", dout1, vecs[k].dout[1]);
            check("vec dout2", dout2, vecs[k].dout[2]);
            check("vec dout3", dout3, vecs[k].dout[3]);
            check("vec eject_valid", pe.eject_valid, vecs[k].ev);
            if (vecs[k].ev) check("vec eject_flit", pe.eject_flit, vecs[k].ef);
        end

        // Injection into the slot freed by ejection.
        idle();
        all_nonlocal();
        pe.inj_valid = 1'b1;
        pe.inj_dst   = 4'd7;
        pe.inj_data  = 32'hABCD;
        stamp = tnow;
        cycle();
        check("inj queued", fifo_count, 1);
        pe.inj_valid   = 1'b0;
        loc            = mk(1, 20, NODE, 32'hD2);
        din[2]         = loc;
        pe.eject_ready = 1'b1;
        cycle();
        check("freed eject_valid", pe.eject_valid, 1);
        check("freed eject_flit", pe.eject_flit, loc);
        check("freed dout2", dout2, mk(1, stamp, 7, 32'hABCD));
        check("freed dout0", dout0, mk(1, 10, 1, 32'hC0));

        // Backpressure: no free slots, six offers in a row.
        all_nonlocal();
        pe.eject_ready = 1'b0;
        pe.inj_valid   = 1'b1;
        pe.inj_dst     = 4'd2;
        n_enq          = 0;
        for (int c = 0; c < 6; c++) begin
            rdy[c]      = pe.inj_ready;
            n_enq       += int'(rdy[c]);
            pe.inj_data = 32'h100 + c;
            cycle();
        end
        check("full enqueues", n_enq, 4);
        check("full ready 5th", rdy[4], 0);
        check("full ready 6th", rdy[5], 0);
        check("full count", fifo_count, 4);
        check("full no inject", dout0, mk(1, 10, 1, 32'hC0));
        idle();
        cycle();
        check("drain dout0 data", dout0[DATA_W-1:0], 32'h100);
        check("drain dout0 valid", dout0[W-1], 1);
        check("drain dout1", dout1, 0);
        check("drain ready", pe.inj_ready, 1);

        // Reset mid-traffic with three entries queued and valid flits in flight.
        check("pre-reset count", fifo_count, 3);
        all_nonlocal();
        apply_reset();
        idle();
        cycle();
        check("post-reset dout0", dout0, 0);
        check("post-reset count", fifo_count, 0);

        // Timestamp wrap: enqueue at 255 and at 0.
        all_nonlocal();
        for (int k = 0; k < 300 && tnow != 255; k++) cycle();
        check("wrap time_now", time_now, 255);
        pe.inj_valid = 1'b1;
        pe.inj_dst   = 4'd3;
        pe.inj_data  = 32'h1;
        cycle();
        check("wrap time_now 0", time_now, 0);
        pe.inj_dst  = 4'hF;
        pe.inj_data = 32'h2;
        cycle();
        idle();
        cycle();
        check("wrap stamp 255", tfield(dout0), 255);
        check("wrap dst 3", dfield(dout0), 3);
        cycle();
        check("wrap stamp 0", tfield(dout0), 0);
        check("wrap dst F", dfield(dout0), 15);

        // Randomized traffic against the model.
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                din[i] = mk($urandom_range(9) < 7, $urandom_range(255),
                            ($urandom_range(2) == 0) ? NODE : $urandom_range(7), $urandom);
            end
            pe.eject_ready = $urandom_range(1);
            pe.inj_valid   = $urandom_range(4) < 3;
            pe.inj_dst     = DST_W'($urandom_range(15));
            pe.inj_data    = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flit_inject_eject.md
Name: flit_inject_eject

Overview:
- Local-node injection/ejection stage of the BLESS bufferless router. It sits ahead of the age-sorting permutation network.
- Each cycle it removes at most one flit addressed to the local node, and inserts at most one locally generated flit into a free channel slot.
- It creates the timestamp field that the permutation network later sorts on: time is stamped when the flit is enqueued.
- It buffers PE-side traffic in a small FIFO with a valid/ready handshake. The network side never stalls.

Parameters:
- DATA_W, 32: payload width.
- DST_W, 4: destination node ID width.
- TIME_W, 8: timestamp width. A smaller value means an older flit.
- NODE_ID, 0: this router's node ID.
- INJ_DEPTH, 4: injection FIFO depth, a power of two and at least 2.
- Derived W = 1+TIME_W+DST_W+DATA_W. Flit layout is {valid[W-1], time, dst, data[DATA_W-1:0]}.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- din0..din3  in  W each  flits arriving from the link inputs; valid bit = MSB.
- dout0..dout3  out  W each  registered flits to the permutation network.
- inj_valid  in  1  PE offers a flit.
- inj_ready  out  1  FIFO can accept; equals !full, combinational from state.
- inj_dst  in  DST_W  destination of the offered flit.
- inj_data  in  DATA_W  payload of the offered flit.
- eject_ready  in  1  PE can accept an ejected flit this cycle.
- eject_valid  out  1  registered; eject_flit holds a valid flit.
- eject_flit  out  W  registered ejected flit.
- fifo_count  out  clog2(INJ_DEPTH)+1  current FIFO occupancy.
- time_now  out  TIME_W  free-running cycle counter.

Behaviour:
- Reset (asynchronous): dout0..3=0, eject_valid=0, eject_flit=0, FIFO empty, fifo_count=0, time_now=0, inj_ready=1. Reset asserted mid-operation discards all FIFO contents and in-flight flits immediately.
- time_now: increments by 1 every cycle and wraps modulo 2^TIME_W. No saturation.
- Enqueue: occurs when inj_valid && inj_ready at the edge. The stored entry is {1'b1, time_now, inj_dst, inj_data}.
- Full FIFO: inj_ready=0 even if a dequeue happens in the same cycle, so there is no same-cycle refill when full.
- Ejection candidates: input slots i with valid=1 and dst==NODE_ID.
  - If eject_ready=1 and at least one candidate exists, eject the candidate with the smallest time field. Ties go to the lowest index.
  - The ejected flit goes to eject_flit next cycle with eject_valid=1, and its slot is treated as free.
  - If eject_ready=0, all candidates pass through unchanged; they are deflected onward and not dropped.
  - With no ejection, eject_valid=0 next cycle and eject_flit holds its old value.
- Time comparison for ejection: plain unsigned. Wrap-around ordering is not corrected in this block.
- Free slots: input slots with valid=0, plus the slot just ejected.
- Injection: if the FIFO is non-empty and a free slot exists, place the FIFO head into the lowest-index free slot and dequeue it. Otherwise the head waits.
- Slot priority: ejection and injection resolve in one cycle, ejection first. Injection may reuse the ejected slot.
- Slot output: non-ejected, non-injected slots pass din to dout unchanged. A free slot that is not injected outputs all-zero.
- Latency: din to dout is 1 cycle, registered; din to eject_flit is 1 cycle. FIFO enqueue to earliest injection is the next cycle, giving a minimum of 2 cycles from inj_valid to dout.
- Simultaneous enqueue and dequeue when not full: occupancy is unchanged and pointers advance independently, wrapping at INJ_DEPTH.
- Empty FIFO: no injection; free slots output zero.
- Flit conservation: every valid input appears exactly once, either on dout or on eject_flit.

Test Plan:
- Reset mid-traffic: fill the FIFO with 3 entries, assert reset for 1 cycle. Expect fifo_count=0, all dout=0, eject_valid=0, time_now=0, inj_ready=1.
- Ejection priority: NODE_ID=5, din1 and din3 valid to dst=5 with times 9 and 4, eject_ready=1. Next cycle expect eject_flit=din3 and dout3=0; dout1 equals din1 unchanged.
- Ejection blocked: same stimulus with eject_ready=0. Expect eject_valid=0 next cycle and dout1, dout3 equal to their inputs.
- Injection into freed slot: all four dins valid with din2 dst=NODE_ID, FIFO holds one flit dst=7, data=0xABCD. Expect the ejection of din2, and dout2 carrying the injected flit with valid=1, dst=7, data=0xABCD and time equal to its enqueue time.
- FIFO full/backpressure: all dins valid and none local, inj_valid=1 for 6 cycles. Expect exactly 4 enqueues, inj_ready=0 from the 5th cycle, and fifo_count=4 with nothing injected. Then drop all din valids: expect head injected into dout0 and inj_ready=1 the following cycle.
- Timestamp wrap: TIME_W=8, enqueue at time_now=255 and again at time_now=0. Expect stamped times 255 and 0 respectively, with no X or carry into the dst field.
